division_u8: RTL and testbench
==============================

# division_u8

Unsigned sequential integer divider for the 8-bit accumulator datapath. It computes quotient and remainder of dividend A by divisor B using a restoring shift-subtract algorithm, one quotient bit per clock. It serves the processor's DIV instruction, where Res feeds ACC and Rem feeds EXT. It uses a start/busy/done handshake with fixed latency.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits. All statements below use WIDTH=8.

Ports (name, direction, width, meaning):
- main_clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  request a division; sampled only while busy=0.
- A  in  WIDTH  dividend, unsigned; captured when start is accepted.
- B  in  WIDTH  divisor, unsigned; captured when start is accepted.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse marking that Res and Rem are valid.
- Res  out  WIDTH  quotient, floor(A/B).
- Rem  out  WIDTH  remainder, A − B·Res.
- div_by_zero  out  1  set with done when the captured B was 0.

## Operation
- States: IDLE and RUN. A 4-bit iteration counter tracks progress.
- Reset (asynchronous, rstn=0):
  - Enter IDLE.
  - busy=0, done=0, div_by_zero=0, Res=0, Rem=0.
  - Internal operand, partial-remainder and counter registers are cleared.
- IDLE with start=1:
  - Latch A into the quotient/shift register and B into the divisor register.
  - Clear the partial remainder. Set counter=WIDTH. Go to RUN with busy=1.
- RUN, each cycle:
  - Form the WIDTH+1-bit partial remainder P' = {P, msb of shift register}, then shift the shift register left by one.
  - If P' ≥ divisor: P = P' − divisor and the new quotient LSB is 1. Otherwise P = P' and the new LSB is 0.
  - Decrement the counter.
- Completion, on the cycle the counter reaches 0:
  - Res gets the shift register and Rem gets P[WIDTH-1:0].
  - div_by_zero = (divisor == 0). done=1 for exactly one cycle, busy=0. Return to IDLE.
- Divide by zero: no special path. The algorithm naturally yields Res=all ones (8'hFF) and Rem=A. div_by_zero=1. Latency is identical to a normal division.
- Res, Rem and div_by_zero hold their values until the next completion or reset. They are not cleared by a new start.
- start while busy=1 is ignored, and operands are not re-sampled.
- A and B may change freely after acceptance without affecting the result.
- Arithmetic:
  - Purely unsigned.
  - The partial remainder is WIDTH+1 bits wide, so the subtract compare never overflows.
  - Rem < B is always true for B≠0.

## Timing
- start is accepted at rising edge k (busy=0 before the edge). busy=1 after edge k.
- Iterations run on edges k+1 … k+8.
- After edge k+8: Res, Rem and div_by_zero are valid, done=1, busy=0.
- After edge k+9: done=0.
- Latency from accepting edge to done is WIDTH (8) cycles. Throughput is one division per WIDTH+1 cycles.
- start held high continuously restarts at edge k+9, the first edge with busy=0. A start coinciding with edge k+8 is ignored because busy is still 1 before that edge.
- Reset mid-operation:
  - Abort immediately (asynchronously).
  - All outputs go to their reset values. No done pulse is produced.
  - After rstn rises, the block is in IDLE and accepts start on the next edge.

## Test plan
- A=100, B=7, pulse start → after 8 cycles done=1 for one cycle, Res=14, Rem=2, div_by_zero=0.
- A=255, B=1 → Res=255, Rem=0. Then A=4, B=4 → Res=1, Rem=0.
- A=3, B=10 → Res=0, Rem=3. Then A=5, B=0 → Res=8'hFF, Rem=5, div_by_zero=1, same 8-cycle latency.
- Accept A=200, B=9. Two cycles later assert start with A=50, B=5 and change A/B → result Res=22, Rem=2. Only one done pulse. The second start is ignored.
- Hold start=1 continuously with A=12, B=4 → done pulses every 9 cycles, each with Res=3, Rem=0.
- Drop rstn low 4 cycles into a division → busy, done, Res and Rem are 0 immediately, with no done pulse afterward. After release, A=9, B=2 → Res=4, Rem=1.

Source files
------------

// File: rtl/division_u8.sv
// rtl/division_u8.sv - unsigned restoring shift-subtract divider, one quotient bit per clock
module division_u8 #(
    parameter int WIDTH = 8
) (
    input  logic             main_clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Res,
    output logic [WIDTH-1:0] Rem,
    output logic             div_by_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] part_next;
    logic [WIDTH-1:0] quo_next;

    always_ff @(posedge main_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            quo_q   <= '0;
            dvs_q   <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // One restoring step: the difference is below the divisor, so WIDTH bits hold it.
    always_comb begin
        trial = {part_q, quo_q[WIDTH-1]};
        if (trial >= {1'b0, dvs_q}) begin
            part_next = trial[WIDTH-1:0] - dvs_q;
            quo_next  = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            part_next = trial[WIDTH-1:0];
            quo_next  = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        res_d   = res_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    quo_d   = A;
                    dvs_d   = B;
                    part_d  = '0;
                    cnt_d   = CNT_INIT;
                    state_d = RUN;
                end
            end
            RUN: begin
                quo_d  = quo_next;
                part_d = part_next;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d   = quo_next;
                    rem_d   = part_next;
                    dbz_d   = (dvs_q == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == RUN);
        done        = done_q;
        Res         = res_q;
        Rem         = rem_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_division_u8.sv
// tb/tb_division_u8.sv - randomized self-checking bench for division_u8 against an arithmetic model
module tb_division_u8;

    logic       main_clk = 1'b0;
    logic       rstn     = 1'b0;
    logic       start    = 1'b0;
    logic [7:0] A        = '0;
    logic [7:0] B        = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] Res, Rem;

    int checks   = 0;
    int failures = 0;

    division_u8 #(.WIDTH(8)) dut (
        .main_clk    (main_clk),
        .rstn        (rstn),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Res         (Res),
        .Rem         (Rem),
        .div_by_zero (div_by_zero)
    );

    always #5 main_clk = ~main_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_res(input logic [7:0] a, input logic [7:0] b);
        return (b == 0) ? 8'hFF : 8'(a / b);
    endfunction

    function automatic logic [7:0] model_rem(input logic [7:0] a, input logic [7:0] b);
        return (b == 0) ? a : 8'(a % b);
    endfunction

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    // Accept one division, scramble the inputs, then check latency, results and the done pulse width.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b, input string tag);
        int n;
        start = 1'b1; A = a; B = b;
        tick();
        start = 1'b0; A = 8'($urandom); B = 8'($urandom);
        check({tag, "_busy"}, busy, 1);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_res"}, Res, model_res(a, b));
        check({tag, "_rem"}, Rem, model_rem(a, b));
        check({tag, "_dbz"}, div_by_zero, (b == 0));
        check({tag, "_busy_at_done"}, busy, 0);
        tick();
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int dones;
        int last_t;
        logic [7:0] ra, rb;

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", Res, 0);
        check("rst_rem", Rem, 0);
        check("rst_dbz", div_by_zero, 0);
        tick();
        rstn = 1'b1;
        tick();

        do_div(8'd100, 8'd7, "d100_7");
        do_div(8'd255, 8'd1, "d255_1");
        do_div(8'd4, 8'd4, "d4_4");
        do_div(8'd3, 8'd10, "d3_10");
        do_div(8'd5, 8'd0, "d5_0");

        // Results persist while idle and are not cleared by a new start.
        tick();
        check("hold_res", Res, 8'hFF);
        check("hold_rem", Rem, 5);

        // Start during busy must be ignored.
        start = 1'b1; A = 8'd200; B = 8'd9;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; A = 8'd50; B = 8'd5;
        tick();
        A = 8'd77; B = 8'd3;
        tick();
        start = 1'b0; A = 8'd1; B = 8'd1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                dones++;
                check("ign_res", Res, 22);
                check("ign_rem", Rem, 2);
            end
            tick();
        end
        check("ign_done_count", dones, 1);

        // Continuous start: a completion every 9 cycles.
        start = 1'b1; A = 8'd12; B = 8'd4;
        dones = 0; last_t = -1;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (done) begin
                if (last_t >= 0) check("cont_period", t - last_t, 9);
                last_t = t;
                dones++;
                check("cont_res", Res, 3);
                check("cont_rem", Rem, 0);
            end
        end
        check("cont_done_count", dones, 4);
        start = 1'b0;
        for (int i = 0; i < 12 && busy; i++) tick();
        check("cont_drained", busy, 0);
        tick();

        // Asynchronous reset four cycles into a division.
        start = 1'b1; A = 8'd200; B = 8'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rstn = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_res", Res, 0);
        check("arst_rem", Rem, 0);
        tick();
        tick();
        rstn = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        check("arst_no_done", dones, 0);
        do_div(8'd9, 8'd2, "d9_2");

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            do_div(ra, rb, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
